// File: rtl/cacheline_adaptor_pkg.sv
// Shared constants and types for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int unsigned s_line    = 256;
  localparam int unsigned s_burst   = 64;
  localparam int unsigned BeatCount = s_line / s_burst;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts single-line cache fill/writeback requests into 4-beat memory bursts.
module cacheline_adaptor #(
  parameter int unsigned s_line  = cacheline_adaptor_pkg::s_line,
  parameter int unsigned s_burst = cacheline_adaptor_pkg::s_burst
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // Cache side
  input  logic [31:0]          pmem_address,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [s_line-1:0]    pmem_wdata,
  output logic [s_line-1:0]    pmem_rdata,
  output logic                 pmem_resp,
  // Memory side
  output logic [31:0]          mem_address,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [s_burst-1:0]   mem_wdata,
  input  logic [s_burst-1:0]   mem_rdata,
  input  logic                 mem_resp
);

  import cacheline_adaptor_pkg::*;

  localparam int unsigned Beats = s_line / s_burst;
  localparam int unsigned CntW  = $clog2(Beats);
  localparam int unsigned OffW  = $clog2(s_line / 8);

  state_e              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [31:0]         r_mem_address;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_pmem_resp;
  logic [s_line-1:0]   r_wline;
  logic [s_line-1:0]   r_rbuf;
  logic [s_line-1:0]   r_pmem_rdata;
  logic                w_last_beat;

  assign w_last_beat  = (r_cnt == CntW'(Beats - 1));

  assign mem_address  = r_mem_address;
  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign pmem_resp    = r_pmem_resp;
  assign pmem_rdata   = r_pmem_rdata;
  // Outgoing beat is selected from the line latched at burst start
  assign mem_wdata    = r_wline[32'(r_cnt) * s_burst +: s_burst];

  // Burst sequencer: request capture, beat counting, fill assembly and completion pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_mem_address <= '0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_pmem_resp   <= 1'b0;
      r_wline       <= '0;
      r_rbuf        <= '0;
      r_pmem_rdata  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (pmem_read) begin
            r_state       <= StRead;
            r_mem_read    <= 1'b1;
            r_mem_address <= {pmem_address[31:OffW], {OffW{1'b0}}};
          end else if (pmem_write) begin
            r_state       <= StWrite;
            r_mem_write   <= 1'b1;
            r_mem_address <= {pmem_address[31:OffW], {OffW{1'b0}}};
            r_wline       <= pmem_wdata;
          end
        end
        StRead: begin
          if (mem_resp) begin
            // Beats arrive lowest first, so shift in from the top
            r_rbuf <= {mem_rdata, r_rbuf[s_line-1:s_burst]};
            r_cnt  <= r_cnt + CntW'(1);
            if (w_last_beat) begin
              r_pmem_rdata <= {mem_rdata, r_rbuf[s_line-1:s_burst]};
              r_mem_read   <= 1'b0;
              r_pmem_resp  <= 1'b1;
              r_state      <= StDone;
            end
          end
        end
        StWrite: begin
          if (mem_resp) begin
            r_cnt <= r_cnt + CntW'(1);
            if (w_last_beat) begin
              r_mem_write <= 1'b0;
              r_pmem_resp <= 1'b1;
              r_state     <= StDone;
            end
          end
        end
        StDone: begin
          r_pmem_resp <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus randomized bursts.
module tb_cacheline_adaptor;

  logic         clk;
  logic         reset_n;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_cmp = 0;
  int n_bad = 0;
  // Reference: the line the cache should currently see on pmem_rdata
  logic [255:0] exp_rdata = '0;

  cacheline_adaptor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || pmem_resp !== 1'b0 ||
        mem_address !== 32'h0 || mem_wdata !== 64'h0 || pmem_rdata !== 256'h0) begin
      n_bad++;
      $display("FAIL %s: rd=%b wr=%b resp=%b addr=%h wdata=%h rdata=%h, required all 0",
               name, mem_read, mem_write, pmem_resp, mem_address, mem_wdata, pmem_rdata);
    end
  endtask

  // Idle cycles with random spurious mem_resp; nothing may move
  task automatic idle(input int n);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_resp  = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
      step();
      n_cmp++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || pmem_resp !== 1'b0 ||
          pmem_rdata !== exp_rdata) begin
        n_bad++;
        $display("FAIL idle: rd=%b wr=%b resp=%b rdata=%h, required 0 0 0 rdata=%h",
                 mem_read, mem_write, pmem_resp, pmem_rdata, exp_rdata);
      end
    end
    mem_resp = 1'b0;
  endtask

  // Full line fill. lead = cycles before the burst may start; stall<0 means random waits.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line, input int lead,
                         input int stall, input logic also_write);
    logic [31:0] exp_addr;
    int          ns;
    exp_addr     = addr & 32'hFFFF_FFE0;
    pmem_address = addr;
    pmem_read    = 1'b1;
    pmem_write   = also_write;
    pmem_wdata   = rand_line();
    mem_resp     = 1'b0;
    for (int i = 0; i < lead; i++) begin
      step();
      n_cmp++;
      if (mem_read !== 1'b0 || pmem_resp !== 1'b0) begin
        n_bad++;
        $display("FAIL rd_lead: mem_read=%b pmem_resp=%b, required 0 0", mem_read, pmem_resp);
      end
    end
    step();
    n_cmp++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== exp_addr) begin
      n_bad++;
      $display("FAIL rd_start: rd=%b wr=%b addr=%h, required 1 0 %h",
               mem_read, mem_write, mem_address, exp_addr);
    end
    for (int b = 0; b < 4; b++) begin
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < ns; s++) begin
        mem_resp     = 1'b0;
        mem_rdata    = {$urandom, $urandom};
        pmem_address = $urandom;
        step();
        n_cmp++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || pmem_resp !== 1'b0 ||
            mem_address !== exp_addr || pmem_rdata !== exp_rdata) begin
          n_bad++;
          $display("FAIL rd_stall: rd=%b wr=%b resp=%b addr=%h rdata=%h, required 1 0 0 %h %h",
                   mem_read, mem_write, pmem_resp, mem_address, pmem_rdata, exp_addr, exp_rdata);
        end
      end
      mem_resp     = 1'b1;
      mem_rdata    = line[b*64 +: 64];
      pmem_address = $urandom;
      step();
      if (b < 3) begin
        n_cmp++;
        if (mem_read !== 1'b1 || pmem_resp !== 1'b0 || mem_address !== exp_addr ||
            pmem_rdata !== exp_rdata) begin
          n_bad++;
          $display("FAIL rd_beat%0d: rd=%b resp=%b addr=%h rdata=%h, required 1 0 %h %h",
                   b, mem_read, pmem_resp, mem_address, pmem_rdata, exp_addr, exp_rdata);
        end
      end else begin
        exp_rdata = line;
        n_cmp++;
        if (pmem_resp !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
            pmem_rdata !== exp_rdata) begin
          n_bad++;
          $display("FAIL rd_done: resp=%b rd=%b wr=%b rdata=%h, required 1 0 0 %h",
                   pmem_resp, mem_read, mem_write, pmem_rdata, exp_rdata);
        end
      end
    end
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  // Full line writeback; every outgoing beat is checked against the requested line.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int lead,
                          input int stall);
    logic [31:0] exp_addr;
    int          ns;
    exp_addr     = addr & 32'hFFFF_FFE0;
    pmem_address = addr;
    pmem_write   = 1'b1;
    pmem_read    = 1'b0;
    pmem_wdata   = line;
    mem_resp     = 1'b0;
    for (int i = 0; i < lead; i++) begin
      step();
      n_cmp++;
      if (mem_write !== 1'b0 || pmem_resp !== 1'b0) begin
        n_bad++;
        $display("FAIL wr_lead: mem_write=%b pmem_resp=%b, required 0 0", mem_write, pmem_resp);
      end
    end
    step();
    pmem_wdata = rand_line();
    n_cmp++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== exp_addr ||
        mem_wdata !== line[63:0]) begin
      n_bad++;
      $display("FAIL wr_start: wr=%b rd=%b addr=%h wdata=%h, required 1 0 %h %h",
               mem_write, mem_read, mem_address, mem_wdata, exp_addr, line[63:0]);
    end
    for (int b = 0; b < 4; b++) begin
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s < ns; s++) begin
        mem_resp     = 1'b0;
        pmem_address = $urandom;
        step();
        n_cmp++;
        if (mem_write !== 1'b1 || pmem_resp !== 1'b0 || mem_address !== exp_addr ||
            mem_wdata !== line[b*64 +: 64]) begin
          n_bad++;
          $display("FAIL wr_stall%0d: wr=%b resp=%b addr=%h wdata=%h, required 1 0 %h %h",
                   b, mem_write, pmem_resp, mem_address, mem_wdata, exp_addr, line[b*64 +: 64]);
        end
      end
      mem_resp     = 1'b1;
      pmem_address = $urandom;
      step();
      if (b < 3) begin
        n_cmp++;
        if (mem_write !== 1'b1 || pmem_resp !== 1'b0 || mem_wdata !== line[(b+1)*64 +: 64]) begin
          n_bad++;
          $display("FAIL wr_beat%0d: wr=%b resp=%b wdata=%h, required 1 0 %h",
                   b, mem_write, pmem_resp, mem_wdata, line[(b+1)*64 +: 64]);
        end
      end else begin
        n_cmp++;
        if (pmem_resp !== 1'b1 || mem_write !== 1'b0 || mem_read !== 1'b0 ||
            pmem_rdata !== exp_rdata) begin
          n_bad++;
          $display("FAIL wr_done: resp=%b wr=%b rd=%b rdata=%h, required 1 0 0 %h",
                   pmem_resp, mem_write, mem_read, pmem_rdata, exp_rdata);
        end
      end
    end
    mem_resp   = 1'b0;
    pmem_write = 1'b0;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    #1;
    check_all_zero("reset_async");
    step();
    step();
    check_all_zero("reset_held");
    reset_n   = 1'b1;
    exp_rdata = '0;
    idle(2);
  endtask

  task automatic test_read_zero_wait();
    do_read(32'h1234_5678, {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}}, 0, 0, 1'b0);
  endtask

  task automatic test_write_stalled();
    do_write(32'hCAFE_0040, {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}}, 1, 2);
  endtask

  task automatic test_simultaneous();
    do_read(32'h0000_1F3C, rand_line(), 1, 0, 1'b1);
  endtask

  task automatic test_spurious();
    idle(6);
  endtask

  task automatic test_reset_mid_burst();
    pmem_address = 32'h8000_0100;
    pmem_read    = 1'b1;
    step();
    mem_resp  = 1'b1;
    mem_rdata = {$urandom, $urandom};
    step();
    mem_rdata = {$urandom, $urandom};
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_mid_burst");
    mem_resp  = 1'b0;
    pmem_read = 1'b0;
    step();
    check_all_zero("reset_mid_hold");
    reset_n   = 1'b1;
    exp_rdata = '0;
    do_read(32'h8000_0100, rand_line(), 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_write($urandom, rand_line(), 1, 0);
    do_read($urandom, rand_line(), 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int lead;
    for (int i = 0; i < 12; i++) begin
      lead = 1;
      if ($urandom_range(0, 1) == 1) begin
        idle(int'($urandom_range(1, 3)));
        lead = 0;
      end
      if ($urandom_range(0, 1) == 1) do_read($urandom, rand_line(), lead, -1, 1'b0);
      else                           do_write($urandom, rand_line(), lead, -1);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_stalled();
    test_simultaneous();
    test_spurious();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter s_line, default 256, cache line width in bits.
REQ-002 SHALL have parameter s_burst, default 64, memory beat width in bits; s_line/s_burst = 4 beats.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pmem_address  input  32  line address from cache datapath.
REQ-006 SHALL have port pmem_read  input  1  cache line-fill request, level, held until pmem_resp.
REQ-007 SHALL have port pmem_write  input  1  cache writeback request, level, held until pmem_resp.
REQ-008 SHALL have port pmem_wdata  input  256  dirty line to write back.
REQ-009 SHALL have port pmem_rdata  output  256  assembled fill line.
REQ-010 SHALL have port pmem_resp  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL have port mem_address  output  32  line-aligned burst address.
REQ-012 SHALL have port mem_read  output  1  burst read request.
REQ-013 SHALL have port mem_write  output  1  burst write request.
REQ-014 SHALL have port mem_wdata  output  64  current outgoing beat.
REQ-015 SHALL have port mem_rdata  input  64  incoming beat, valid when mem_resp high.
REQ-016 SHALL have port mem_resp  input  1  per-beat accept/valid strobe from memory.

Function
REQ-017 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-018 IDLE: sample requests each cycle; pmem_read -> READ; else pmem_write -> WRITE; both high -> READ (read priority).
REQ-019 On leaving IDLE SHALL latch mem_address = {pmem_address[31:5], 5'b0}, latch pmem_wdata (write), clear 2-bit beat counter.
REQ-020 READ: mem_read=1; each cycle with mem_resp=1 SHALL store mem_rdata into line bits [64k+63:64k], k = beat counter, then increment k.
REQ-021 WRITE: mem_write=1; mem_wdata = latched line bits [64k+63:64k]; each cycle with mem_resp=1 SHALL increment k.
REQ-022 mem_read/mem_write SHALL stay high through the cycle the 4th beat is accepted, deassert the next cycle.
REQ-023 After 4th accepted beat (k=3 with mem_resp) SHALL go to DONE; DONE asserts pmem_resp=1 for exactly one cycle, then returns to IDLE.
REQ-024 pmem_rdata SHALL hold the last assembled line from DONE until the next read completes.
REQ-025 Cycles with mem_resp=0 inside a burst SHALL stall without advancing k or changing outputs.
REQ-026 mem_resp in IDLE or DONE SHALL be ignored.
REQ-027 Requests SHALL not be sampled in DONE; earliest next burst starts 2 cycles after the DONE cycle (DONE -> IDLE -> READ/WRITE).
REQ-028 Latency: read completion pulse = 1 (IDLE->READ) + 4 beat cycles (zero memory wait) + 1 DONE cycle after request.
REQ-029 Changes on pmem_address/pmem_wdata during a burst SHALL not affect the burst in progress.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, k=0, mem_read=0, mem_write=0, pmem_resp=0, mem_address=0, mem_wdata=0, pmem_rdata=0.
REQ-031 Reset mid-burst SHALL abandon the burst; no pmem_resp pulse is produced for it.

Structure
REQ-032 Shared package SHALL hold s_line, s_burst, beat count constant (4) and the state enum type.
REQ-033 SHALL be a single module; no sub-module (counter and shift/insert logic are trivial).

Verification
REQ-034 Read, zero-wait: pmem_read, pmem_address=0x1234_5678, beats 0x0..0,0x1..1,0x2..2,0x3..3 -> mem_address=0x1234_5660, pmem_rdata={beat3,beat2,beat1,beat0}, pmem_resp one cycle.
REQ-035 Write, stalled: pmem_wdata=0xA..A_B..B_C..C_D..D, mem_resp low 2 cycles between beats -> mem_wdata sequence D,C,B,A, each held across stall, one pmem_resp.
REQ-036 Simultaneous pmem_read and pmem_write in IDLE -> mem_read asserted, mem_write stays 0.
REQ-037 reset_n low after 2 read beats -> all outputs 0 immediately, no pmem_resp; following read completes normally.
REQ-038 Spurious mem_resp in IDLE with no request -> no state change, pmem_rdata unchanged.
REQ-039 Back-to-back writeback then fill -> second burst starts exactly 2 cycles after the first pmem_resp.
